// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command queue: idle byte default and FSM state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_cmd_queue_sync_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush; head is the show-ahead read data.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign level   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Flush wins over push; the pop side may still consume the head this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_queue.sv
// Command byte queue feeding the UART transmit input one frame at a time, with optional idle gap frames.
module uart_cmd_queue
  import uart_cmd_pkg::*;
#(
  parameter int         DEPTH      = 8,
  parameter int         AW         = 3,
  parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEF,
  parameter int         GAP_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd_bits,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        flush,
  input  logic        tx_ready,
  output logic [7:0]  tx_bits,
  output logic [AW:0] level,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] sent_cnt
);

  state_t     state;
  logic [7:0] gap_cnt;
  logic       full;
  logic       empty;
  logic [7:0] head;
  logic       load_slot;
  logic       pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (pop),
    .flush (flush),
    .din   (cmd_bits),
    .level (level),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign cmd_ready = !full;
  assign busy      = (state != ST_IDLE) || (level != '0);

  // Frame boundaries where the next command may be taken from the head.
  assign load_slot = tx_ready && ((state == ST_IDLE) ||
                                  ((state == ST_SEND) && (GAP_FRAMES == 0)) ||
                                  ((state == ST_GAP) && (gap_cnt == 8'd0)));
  assign pop       = load_slot && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_bits  <= IDLE_BYTE;
      gap_cnt  <= 8'd0;
      sent_cnt <= 16'd0;
    end else if (load_slot) begin
      if (!empty) begin
        tx_bits  <= head;
        sent_cnt <= sent_cnt + 16'd1;
        state    <= ST_SEND;
      end else begin
        tx_bits <= IDLE_BYTE;
        state   <= ST_IDLE;
      end
    end else if (tx_ready) begin
      case (state)
        ST_SEND: begin
          tx_bits <= IDLE_BYTE;
          gap_cnt <= 8'(GAP_FRAMES - 1);
          state   <= ST_GAP;
        end
        ST_GAP:  gap_cnt <= gap_cnt - 8'd1;
        default: begin
          tx_bits <= IDLE_BYTE;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               overflow <= 1'b0;
    else if (cmd_valid && full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_cmd_queue.sv
// Directed bench for uart_cmd_queue: one instance with a gap frame, one back-to-back.
module tb_uart_cmd_queue;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_bits;
  logic        cmd_valid;
  logic        flush;
  logic        tx_ready;
  logic        cmd_ready;
  logic [7:0]  tx_bits;
  logic [3:0]  level;
  logic        busy;
  logic        overflow;
  logic [15:0] sent_cnt;

  logic [7:0]  cmd_bits_b;
  logic        cmd_valid_b;
  logic        cmd_ready_b;
  logic [7:0]  tx_bits_b;
  logic [3:0]  level_b;
  logic        busy_b;
  logic        overflow_b;
  logic [15:0] sent_cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_cmd_queue #(.GAP_FRAMES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_bits(cmd_bits), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .flush(flush), .tx_ready(tx_ready), .tx_bits(tx_bits),
    .level(level), .busy(busy), .overflow(overflow), .sent_cnt(sent_cnt)
  );

  uart_cmd_queue #(.GAP_FRAMES(0)) u_dut_b2b (
    .clk(clk), .rst_n(rst_n), .cmd_bits(cmd_bits_b), .cmd_valid(cmd_valid_b),
    .cmd_ready(cmd_ready_b), .flush(flush), .tx_ready(tx_ready), .tx_bits(tx_bits_b),
    .level(level_b), .busy(busy_b), .overflow(overflow_b), .sent_cnt(sent_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_valid_b = 1'b0; flush = 1'b0; tx_ready = 1'b0;
    cmd_bits = 8'h00; cmd_bits_b = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    cmd_valid = 1'b1; cmd_bits = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b);
    cmd_valid_b = 1'b1; cmd_bits_b = b;
    @(negedge clk);
    cmd_valid_b = 1'b0;
  endtask

  // Wait out a frame, then pulse tx_ready; returns at the negedge after the boundary.
  task automatic frame();
    repeat (FRAME - 1) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_tx_bits", 32'(tx_bits), 32'h00);
    chk("rst_level", 32'(level), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_sent_cnt", 32'(sent_cnt), 0);

    // single command then its gap frame
    push(8'h21);
    chk("s1_level", 32'(level), 1);
    chk("s1_busy_queued", 32'(busy), 1);
    chk("s1_tx_before", 32'(tx_bits), 32'h00);
    frame();
    chk("s1_frame_cmd", 32'(tx_bits), 32'h21);
    chk("s1_sent", 32'(sent_cnt), 1);
    chk("s1_level_pop", 32'(level), 0);
    frame();
    chk("s1_frame_gap", 32'(tx_bits), 32'h00);
    chk("s1_busy_gap", 32'(busy), 1);
    frame();
    chk("s1_frame_idle", 32'(tx_bits), 32'h00);
    chk("s1_busy_done", 32'(busy), 0);

    // identical commands separated by a gap frame
    push(8'h42);
    push(8'h42);
    frame(); chk("s2_f0", 32'(tx_bits), 32'h42);
    frame(); chk("s2_f1", 32'(tx_bits), 32'h00);
    frame(); chk("s2_f2", 32'(tx_bits), 32'h42);
    frame(); chk("s2_f3", 32'(tx_bits), 32'h00);
    chk("s2_sent", 32'(sent_cnt), 3);

    // fill to full, drop the ninth, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    chk("s3_level_full", 32'(level), 8);
    chk("s3_ready_full", 32'(cmd_ready), 0);
    chk("s3_ovf_before", 32'(overflow), 0);
    push(8'hFF);
    chk("s3_overflow", 32'(overflow), 1);
    chk("s3_level_after", 32'(level), 8);
    for (int i = 0; i < 8; i++) begin
      frame(); chk($sformatf("s3_drain%0d", i), 32'(tx_bits), 32'h80 + 32'(i));
      if (i == 0) chk("s3_level_7", 32'(level), 7);
      frame(); chk($sformatf("s3_gap%0d", i), 32'(tx_bits), 32'h00);
    end
    frame();
    chk("s3_no_dropped", 32'(tx_bits), 32'h00);
    chk("s3_sent", 32'(sent_cnt), 8);
    chk("s3_ovf_sticky", 32'(overflow), 1);

    // flush during the first frame
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    frame();
    chk("s4_first", 32'(tx_bits), 32'h11);
    chk("s4_level_pre", 32'(level), 2);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("s4_level_flush", 32'(level), 0);
    chk("s4_tx_kept", 32'(tx_bits), 32'h11);
    for (int i = 0; i < 3; i++) begin
      frame(); chk($sformatf("s4_idle%0d", i), 32'(tx_bits), 32'h00);
    end
    chk("s4_sent", 32'(sent_cnt), 1);
    chk("s4_busy", 32'(busy), 0);

    // push into empty on the boundary waits one frame; then async reset mid-SEND
    do_reset();
    repeat (FRAME - 1) @(negedge clk);
    cmd_valid = 1'b1; cmd_bits = 8'h55; tx_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; tx_ready = 1'b0;
    chk("s5_not_popped", 32'(tx_bits), 32'h00);
    chk("s5_level_1", 32'(level), 1);
    frame();
    chk("s5_send", 32'(tx_bits), 32'h55);
    push(8'h66);
    chk("s5_level_q", 32'(level), 1);
    rst_n = 1'b0;
    #1;
    chk("s5_async_tx", 32'(tx_bits), 32'h00);
    chk("s5_async_level", 32'(level), 0);
    chk("s5_async_busy", 32'(busy), 0);
    chk("s5_async_sent", 32'(sent_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // back-to-back instance
    do_reset();
    chk("s6_rst_tx", 32'(tx_bits_b), 32'h00);
    push_b(8'h0A);
    push_b(8'h0B);
    chk("s6_level", 32'(level_b), 2);
    frame(); chk("s6_f0", 32'(tx_bits_b), 32'h0A);
    frame(); chk("s6_f1", 32'(tx_bits_b), 32'h0B);
    frame(); chk("s6_f2", 32'(tx_bits_b), 32'h00);
    chk("s6_sent", 32'(sent_cnt_b), 2);
    chk("s6_busy", 32'(busy_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
